// File: rtl/rsa_pkg.sv
// Shared RSA definitions: reducer FSM encoding and default operand width.
// Reused by the exponentiation datapath.
package rsa_pkg;

  localparam int RSA_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mod_reducer_step.sv
// One restoring-reduction step: shift in a product bit, then
// subtract the modulus if the shifted remainder reached it.
module mod_reducer_step
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_mod,
  output logic [WIDTH:0]   o_rem
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;

  assign w_shift = {i_rem, i_bit};
  assign w_ge    = w_shift >= {2'b00, i_mod};
  // Difference is below N whenever it is selected, so W+1 bits suffice.
  assign w_sub   = w_shift[WIDTH:0] - {1'b0, i_mod};
  assign o_rem   = w_ge ? w_sub : w_shift[WIDTH:0];

endmodule

// File: rtl/mod_reducer.sv
// Serial Product mod Modulus reducer, one product bit per cycle,
// MSB first, with divide-by-zero flag.
module mod_reducer
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [2*WIDTH-1:0] Product,
  input  logic [WIDTH-1:0]   Modulus,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Result,
  output logic               Err_Div0
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_prod;
  logic [WIDTH-1:0] r_mod;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   w_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_err;
  logic             w_last;
  logic             w_div0;

  assign w_last   = r_cnt == CW'(PW - 1);
  assign w_div0   = Modulus == '0;
  assign Result   = r_result;
  assign Err_Div0 = r_err;

  mod_reducer_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem(r_rem),
    .i_bit(r_prod[PW-1]),
    .i_mod(r_mod),
    .o_rem(w_rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    Busy   = 1'b0;
    Done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Start) w_next = w_div0 ? DONE : REDUCE;
      end
      REDUCE: begin
        Busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        Done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prod   <= '0;
      r_mod    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else if (r_state == IDLE && Start) begin
      r_prod <= Product;
      r_mod  <= Modulus;
      r_rem  <= '0;
      r_cnt  <= '0;
      if (w_div0) begin
        r_result <= '0;
        r_err    <= 1'b1;
      end
    end else if (r_state == REDUCE) begin
      r_prod <= {r_prod[PW-2:0], 1'b0};
      r_rem  <= w_rem;
      r_cnt  <= r_cnt + CW'(1);
      // Result is captured on the last bit so it is valid with Done.
      if (w_last) begin
        r_result <= w_rem[WIDTH-1:0];
        r_err    <= 1'b0;
      end
    end
  end

endmodule
